chnl_fifo_buffer: RTL and testbench
===================================

# chnl_fifo_buffer

Parametrised valid/ready FIFO for the channel datapath: a DEPTH-entry, first-word-fall-through elastic buffer between a producer and a consumer stage. It generalises the two-entry ping-pong channel buffer to arbitrary depth, adds an occupancy count, an almost-full flag and a synchronous flush. `i_rdy` is a function of registered occupancy only and never depends on `o_rdy`, so it breaks the ready timing path across the block.

## Interface
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `AFULL`, DEPTH-1: almost-full threshold; 1 ≤ AFULL ≤ DEPTH.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all contents.
- `i_val`  in  1  producer data valid.
- `i_rdy`  out  1  buffer can accept; independent of `o_rdy`, `i_val` and `flush`.
- `i_data`  in  WIDTH  producer data.
- `o_val`  out  1  head entry valid.
- `o_rdy`  in  1  consumer accepts head.
- `o_data`  out  WIDTH  head entry data.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  `count >= AFULL`.

## Operation
- Storage: DEPTH×WIDTH array; `wr_ptr`, `rd_ptr` of $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` register.
- push = `i_val && i_rdy`; pop = `o_val && o_rdy`.
- `i_rdy = rst_n && (count != DEPTH)`. `o_val = (count != 0)`. `o_data = mem[rd_ptr]`.
- push: write `i_data` to `mem[wr_ptr]`, `wr_ptr` +1. pop: `rd_ptr` +1.
- count update: push only +1; pop only −1; both or neither unchanged.
- Full (count = DEPTH): `i_rdy` = 0 even if a pop occurs that cycle; `i_rdy` rises the cycle after the pop.
- Empty (count = 0): `o_val` = 0; a push does not bypass to the output in the same cycle.
- Simultaneous push and pop at any 0 < count < DEPTH: both take effect; order preserved.
- `flush` = 1: next cycle `count`, `wr_ptr`, `rd_ptr` = 0; any push or pop in the flush cycle is discarded (handshake completes, data dropped). Flush takes priority over push/pop. Memory contents are not cleared.
- Data are never reordered, duplicated or dropped except by flush.
- Illegal parameters (DEPTH not a power of two or < 2, AFULL out of range) stop elaboration via a generate-time check.

## Timing
- Reset (`rst_n` = 0, asynchronous): `count` = 0, pointers = 0, `o_val` = 0, `i_rdy` = 0, `almost_full` = 0, memory and `o_data` = 0. `i_rdy` rises combinationally with `rst_n` deassertion; the first push is possible on the first rising edge after release.
- Reset mid-operation discards all contents immediately; no handshake completes while `rst_n` = 0.
- Latency: a word pushed on edge N is presented with `o_val` = 1 after edge N (visible in cycle N+1).
- Throughput: one word per cycle sustained when count stays in 1..DEPTH−1; with `o_rdy` held high, occupancy settles at 1.
- `count` and `almost_full` reflect state after the last edge; both are glitch-free functions of registers.

## Test plan
- Reset and first word: hold `rst_n` = 0 for 3 cycles with `i_val` = 1 → `i_rdy`, `o_val`, `count`, `o_data` all 0; release, push 0xA5A5A5A5 → next cycle `o_val` = 1, `o_data` = 0xA5A5A5A5, `count` = 1.
- Fill and full boundary (DEPTH = 4, AFULL = 3): push 1,2,3,4 with `o_rdy` = 0 → `almost_full` rises after the 3rd push, `i_rdy` = 0 after the 4th; pop one with `i_val` = 1 → no push that cycle, `i_rdy` = 1 next cycle, `count` = 3.
- Streaming and wrap: push 0..19 with `o_rdy` = 1 always → outputs 0..19 in order, one per cycle after the first, `count` ≤ 1, pointers wrap 5 times.
- Random backpressure: random `i_val`/`o_rdy` for 10 000 cycles against a scoreboard → exact order match, `count` equals scoreboard depth every cycle, never exceeds 4.
- Flush: fill with 3 words, assert `flush` together with push of 0x77 and `o_rdy` = 1 → next cycle `count` = 0, `o_val` = 0, 0x77 never appears at the output; the next push appears as the first output.
- Async reset mid-stream: deassert `rst_n` between edges at `count` = 2 → `o_val`, `i_rdy`, `count` drop immediately without waiting for a clock edge.

Source files
------------

// File: rtl/chnl_fifo_buffer.sv
// chnl_fifo_buffer: first-word-fall-through valid/ready FIFO for the channel
// datapath. It provides DEPTH entries, an occupancy count, an almost-full
// flag and a synchronous flush. The input ready depends only on registered
// occupancy and on rst_n, so no combinational path runs from o_rdy to i_rdy.
module chnl_fifo_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     i_val,
    output logic                     i_rdy,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_val,
    input  logic                     o_rdy,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // Reject illegal parameterisations at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("chnl_fifo_buffer: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL < 1) || (AFULL > DEPTH)) begin : g_bad_afull
        $error("chnl_fifo_buffer: AFULL must lie in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push;
    logic             pop;

    // Handshakes. i_rdy drops at once while reset is asserted, so no push
    // can complete during reset.
    assign i_rdy       = rst_n && (count_q != FULL_CNT);
    assign o_val       = (count_q != '0);
    assign push        = i_val && i_rdy;
    assign pop         = o_val && o_rdy;
    assign o_data      = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_CNT);

    // Compute next-state pointers and occupancy. Flush overrides any
    // handshake that completes in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Register pointers and occupancy. Reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage entries. Each entry has its own write enable. A push that
    // completes during a flush is dropped, so the flush cycle does not
    // write the array.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [AW-1:0] IDX = AW'(gi);
        logic wr_en;
        assign wr_en = push && !flush && (wr_ptr_q == IDX);

        // Capture producer data into this entry when it is the write target.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[gi] <= '0;
            end else if (wr_en) begin
                mem_q[gi] <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_chnl_fifo_buffer.sv
// Self-checking bench for chnl_fifo_buffer. A queue-based reference model
// holds the FIFO contents. Every cycle the bench compares the DUT outputs
// with that model.
module tb_chnl_fifo_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             i_val;
    logic             i_rdy;
    logic [WIDTH-1:0] i_data;
    logic             o_val;
    logic             o_rdy;
    logic [WIDTH-1:0] o_data;
    logic [2:0]       count;
    logic             almost_full;

    int n_checks;
    int n_errors;
    logic [WIDTH-1:0] model_q[$];

    chnl_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data),
        .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data),
        .count(count), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every visible output with the reference model.
    task automatic check_state();
        int sz;
        sz = model_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("o_val", 32'(o_val), 32'(sz != 0));
        chk("i_rdy", 32'(i_rdy), 32'(sz < DEPTH));
        chk("afull", 32'(almost_full), 32'(sz >= AFULL));
        if (sz != 0) chk("o_data", o_data, model_q[0]);
    endtask

    // Call this at a negedge. It drives one cycle of inputs, lets the edge
    // occur, updates the model and checks the result at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit do_push, do_pop;
        i_val = v; i_data = d; o_rdy = r; flush = f;
        #1;
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() != 0);
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; flush = 1'b0; i_val = 1'b1; o_rdy = 1'b0; i_data = 32'h1234_5678;

        // Hold reset with i_val high. Nothing may be accepted or presented.
        repeat (3) begin
            @(negedge clk);
            chk("rst_i_rdy", 32'(i_rdy), 32'd0);
            chk("rst_o_val", 32'(o_val), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_o_data", o_data, 32'd0);
            chk("rst_afull", 32'(almost_full), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_i_rdy", 32'(i_rdy), 32'd1);
        step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        chk("first_o_val", 32'(o_val), 32'd1);
        chk("first_o_data", o_data, 32'hA5A5_A5A5);
        chk("first_count", 32'(count), 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Fill to full and check the full boundary.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 32'(k), 1'b0, 1'b0);
            chk("fill_afull", 32'(almost_full), 32'(k >= 3));
        end
        chk("full_i_rdy", 32'(i_rdy), 32'd0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("after_pop_i_rdy", 32'(i_rdy), 32'd1);
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_head", o_data, 32'd2);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Stream with o_rdy held high. Occupancy stays at 1 or below.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 32'(k), 1'b1, 1'b0);
            chk("stream_cnt_le1", 32'(count <= 1), 32'd1);
            chk("stream_head", o_data, 32'(k));
        end
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while a push and a pop complete in the same cycle.
        for (int k = 0; k < 3; k++) step(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_o_val", 32'(o_val), 32'd0);
        step(1'b1, 32'h88, 1'b0, 1'b0);
        chk("post_flush_head", o_data, 32'h88);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Random traffic with backpressure, checked against the model.
        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 199) == 0));
            chk("rand_cnt_max", 32'(count <= DEPTH), 32'd1);
        end

        // Assert async reset between edges with count = 2.
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 32'h55, 1'b0, 1'b0);
        step(1'b1, 32'h66, 1'b0, 1'b0);
        chk("pre_arst_count", 32'(count), 32'd2);
        i_val = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("arst_o_val", 32'(o_val), 32'd0);
        chk("arst_i_rdy", 32'(i_rdy), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h99, 1'b0, 1'b0);
        chk("post_arst_head", o_data, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
